// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module      : id_ex_stage_if
// Description : Decode-to-execute bus. Decode drives the instruction fields.
//               The execute stage returns the load-use freeze request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_if;
  logic       id_valid;
  logic [7:0] id_rs1_data;
  logic [7:0] id_rs2_data;
  logic [7:0] id_imm;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic [2:0] id_alu_ctrl;
  logic       id_alu_src_imm;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       id_mem_write;
  logic       load_use_stall;

  // Decode side
  modport master (
    output id_valid, id_rs1_data, id_rs2_data, id_imm,
    output id_rs1, id_rs2, id_rd, id_alu_ctrl,
    output id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write,
    input  load_use_stall
  );

  // Execute-stage side
  modport slave (
    input  id_valid, id_rs1_data, id_rs2_data, id_imm,
    input  id_rs1, id_rs2, id_rd, id_alu_ctrl,
    input  id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write,
    output load_use_stall
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with operand forwarding, load-use
//               hazard detection, flush/stall handling and bubble counting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  id_bus,
  input  logic          stall,
  input  logic          flush,
  input  logic [4:0]    exmem_rd,
  input  logic [4:0]    memwb_rd,
  input  logic          exmem_reg_write,
  input  logic          memwb_reg_write,
  input  logic [7:0]    exmem_result,
  input  logic [7:0]    memwb_result,
  output logic [7:0]    alu_src_a,
  output logic [7:0]    alu_src_b,
  output logic [2:0]    alu_ctrl,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [4:0]    ex_rd,
  output logic [7:0]    ex_store_data,
  output logic [7:0]    bubble_cnt
);

  localparam logic [7:0] C_BUBBLE_MAX = 8'hFF;

  logic [4:0] r_rs1;
  logic [4:0] r_rs2;
  logic [7:0] r_rs1_data;
  logic [7:0] r_rs2_data;
  logic [7:0] r_imm;
  logic       r_alu_src_imm;
  logic       w_load_use;
  logic [7:0] w_fwd_rs1;
  logic [7:0] w_fwd_rs2;
  logic [7:0] w_bubble_next;

  // Youngest producer wins; x0 is never a forwarding target.
  function automatic logic [7:0] fwd_sel(input logic [4:0] rs, input logic [7:0] rf_data,
                                         input logic [4:0] em_rd, input logic em_we,
                                         input logic [7:0] em_res, input logic [4:0] mw_rd,
                                         input logic mw_we, input logic [7:0] mw_res);
    logic [7:0] sel;
    sel = rf_data;
    if (em_we && (em_rd != 5'd0) && (em_rd == rs)) begin
      sel = em_res;
    end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == rs)) begin
      sel = mw_res;
    end
    return sel;
  endfunction

  // Load in EX whose destination is read by the instruction in decode
  assign w_load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_bus.id_valid &
                      ((ex_rd == id_bus.id_rs1) | (ex_rd == id_bus.id_rs2));
  assign id_bus.load_use_stall = w_load_use;

  // Saturating bubble counter increment
  assign w_bubble_next = (bubble_cnt == C_BUBBLE_MAX) ? bubble_cnt : bubble_cnt + 8'd1;

  // Operand forwarding and ALU operand selection
  always_comb begin
    w_fwd_rs1     = fwd_sel(r_rs1, r_rs1_data, exmem_rd, exmem_reg_write, exmem_result,
                            memwb_rd, memwb_reg_write, memwb_result);
    w_fwd_rs2     = fwd_sel(r_rs2, r_rs2_data, exmem_rd, exmem_reg_write, exmem_result,
                            memwb_rd, memwb_reg_write, memwb_result);
    alu_src_a     = w_fwd_rs1;
    alu_src_b     = r_alu_src_imm ? r_imm : w_fwd_rs2;
    ex_store_data = w_fwd_rs2;
  end

  // Pipeline register: flush > stall > load-use bubble > normal load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_rd         <= 5'd0;
      alu_ctrl      <= 3'd0;
      r_rs1         <= 5'd0;
      r_rs2         <= 5'd0;
      r_rs1_data    <= 8'd0;
      r_rs2_data    <= 8'd0;
      r_imm         <= 8'd0;
      r_alu_src_imm <= 1'b0;
      bubble_cnt    <= 8'd0;
    end else if (flush || (!stall && w_load_use)) begin
      // Bubble: operand fields are left as-is, only validity/controls drop
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      bubble_cnt    <= w_bubble_next;
    end else if (!stall) begin
      ex_valid      <= id_bus.id_valid;
      ex_reg_write  <= id_bus.id_valid & id_bus.id_reg_write;
      ex_mem_read   <= id_bus.id_valid & id_bus.id_mem_read;
      ex_mem_write  <= id_bus.id_valid & id_bus.id_mem_write;
      ex_rd         <= id_bus.id_rd;
      alu_ctrl      <= id_bus.id_alu_ctrl;
      r_rs1         <= id_bus.id_rs1;
      r_rs2         <= id_bus.id_rs2;
      r_rs1_data    <= id_bus.id_rs1_data;
      r_rs2_data    <= id_bus.id_rs2_data;
      r_imm         <= id_bus.id_imm;
      r_alu_src_imm <= id_bus.id_alu_src_imm;
    end
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: id_valid  in  1  decode slot holds a real instruction.
REQ-004 SHALL: id_rs1_data, id_rs2_data, id_imm  in  8 each  register-file operands and immediate.
REQ-005 SHALL: id_rs1, id_rs2, id_rd  in  5 each  register addresses.
REQ-006 SHALL: id_alu_ctrl  in  3  ALU operation code, same encoding as the ALU ctrl input.
REQ-007 SHALL: id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write  in  1 each  decode controls.
REQ-008 SHALL: stall  in  1  downstream hold request; flush  in  1  squash request (taken branch).
REQ-009 SHALL: exmem_rd, memwb_rd  in  5 each; exmem_reg_write, memwb_reg_write  in  1 each; exmem_result, memwb_result  in  8 each  forwarding sources.
REQ-010 SHALL: alu_src_a, alu_src_b  out  8 each  ALU operands; alu_ctrl  out  3  ALU op.
REQ-011 SHALL: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each; ex_rd  out  5; ex_store_data  out  8  forwarded rs2.
REQ-012 SHALL: load_use_stall  out  1  combinational request to freeze fetch/decode.
REQ-013 SHALL: bubble_cnt  out  8  count of inserted bubbles.

Function
REQ-014 SHALL: pipeline register captures all id_* fields, with one-cycle latency from decode to ALU inputs.
REQ-015 SHALL: update priority per edge: flush > stall > load_use_stall > normal load.
REQ-016 SHALL: flush: ex_valid<=0 and ex_reg_write, ex_mem_read, ex_mem_write<=0 (bubble), regardless of stall.
REQ-017 SHALL: stall (no flush): every register holds its value; bubble_cnt unchanged.
REQ-018 SHALL: load_use_stall (no flush, no stall): insert bubble as REQ-016.
REQ-019 SHALL: normal load: ex_valid<=id_valid; controls loaded gated by id_valid (all zero when id_valid=0).
REQ-020 SHALL: load_use_stall = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
REQ-021 SHALL: forwarding is combinational on registered rs1/rs2: EX/MEM match wins over MEM/WB match; match requires reg_write=1 and rd!=0 and rd==rs.
REQ-022 SHALL: no match -> registered register-file data used.
REQ-023 SHALL: alu_src_a = forwarded rs1; alu_src_b = id_imm registered if alu_src_imm else forwarded rs2; ex_store_data = forwarded rs2 always.
REQ-024 SHALL: alu_ctrl = registered id_alu_ctrl; values 110/111 passed through unchanged.
REQ-025 SHALL: bubble_cnt increments by 1 on each edge where REQ-016 or REQ-018 bubble applied; saturates at 255, never wraps.
REQ-026 SHALL: ALU arithmetic is 8-bit; this block performs no arithmetic beyond bubble_cnt.

Reset
REQ-027 SHALL: rst_n low asynchronously clears every register to 0: ex_valid, controls, ex_rd, operands, alu_ctrl (000), bubble_cnt.
REQ-028 SHALL: during reset outputs read 0, load_use_stall=0; mid-operation reset discards in-flight instruction.
REQ-029 SHALL: first capture occurs on the first rising edge with rst_n high.

Verification
REQ-030 SHALL: load id_rs1_data=0x12, id_rs2_data=0x34, alu_src_imm=0, no hazards -> next cycle alu_src_a=0x12, alu_src_b=0x34, ex_valid=1.
REQ-031 SHALL: registered rs1=5, exmem_rd=5/write=1/result=0xAA, memwb_rd=5/write=1/result=0xBB -> alu_src_a=0xAA; with exmem_rd=0 -> 0xBB.
REQ-032 SHALL: EX holds load to rd=3, id_rs2=3, id_valid=1 -> load_use_stall=1; next edge ex_valid=0, bubble_cnt+1.
REQ-033 SHALL: flush=1 and stall=1 same edge -> ex_valid=0, ex_reg_write=0; stall=1 alone -> all outputs unchanged.
REQ-034 SHALL: 260 consecutive flush edges -> bubble_cnt=255; assert rst_n=0 mid-clock -> bubble_cnt=0 immediately.
REQ-035 SHALL: forwarding with rd=0 and reg_write=1, result=0xFF -> register-file value used, not 0xFF.
